// File: rtl/disp_timing_ctrl.sv
// Display timing controller: DE/HSYNC/VSYNC generation for 640x480, 800x600
// and 1280x1024. The output is blanked and re-settled on enable or mode change.
// Optional feature macro: DISP_TIMING_VBLIRQ_EN (adds IRQ_CLR / VBL_IRQ).
module disp_timing_ctrl #(
    parameter int unsigned SETTLE_CYC = 1024
) (
    input  logic        DCLK,
    input  logic        ARESETN,
    input  logic [1:0]  RESOL,
    input  logic        DSP_EN,
`ifdef DISP_TIMING_VBLIRQ_EN
    input  logic        IRQ_CLR,
    output logic        VBL_IRQ,
`endif
    output logic        DSP_DE,
    output logic        DSP_HSYNC_X,
    output logic        DSP_VSYNC_X,
    output logic [10:0] HCNT,
    output logic [10:0] VCNT,
    output logic        FRAME_START,
    output logic        READY
);

    localparam int unsigned CW = 11;
    localparam int unsigned SW = 16;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            en_s1, en_s2;
    logic [1:0]      resol_s1, resol_s2;
    logic [1:0]      resol_n;
    logic [1:0]      pend, pend_nxt;
    logic [1:0]      mode, mode_nxt;
    logic [SW-1:0]   cnt, cnt_nxt;
    logic [CW-1:0]   h, h_nxt;
    logic [CW-1:0]   v, v_nxt;
    logic [CW-1:0]   hact, hs_beg, hs_end, htot;
    logic [CW-1:0]   vact, vs_beg, vs_end, vtot;
    logic            run_out;

    // Two-flop synchronisers for the asynchronous mode and enable inputs
    always_ff @(posedge DCLK or negedge ARESETN) begin
        if (!ARESETN) begin
            en_s1    <= 1'b0;
            en_s2    <= 1'b0;
            resol_s1 <= 2'b00;
            resol_s2 <= 2'b00;
        end else begin
            en_s1    <= DSP_EN;
            en_s2    <= en_s1;
            resol_s1 <= RESOL;
            resol_s2 <= resol_s1;
        end
    end

    // Mode 11 is an alias of 640x480, so a 00<->11 toggle is not a mode change
    assign resol_n = (resol_s2 == 2'b11) ? 2'b00 : resol_s2;

    // Timing table of the latched mode, sync windows as half-open [beg,end)
    always_comb begin
        case (mode)
            2'b01: begin
                hact = CW'(800);  hs_beg = CW'(840);  hs_end = CW'(968);  htot = CW'(1056);
                vact = CW'(600);  vs_beg = CW'(601);  vs_end = CW'(605);  vtot = CW'(628);
            end
            2'b10: begin
                hact = CW'(1280); hs_beg = CW'(1328); hs_end = CW'(1440); htot = CW'(1688);
                vact = CW'(1024); vs_beg = CW'(1025); vs_end = CW'(1028); vtot = CW'(1066);
            end
            default: begin
                hact = CW'(640);  hs_beg = CW'(656);  hs_end = CW'(752);  htot = CW'(800);
                vact = CW'(480);  vs_beg = CW'(490);  vs_end = CW'(492);  vtot = CW'(525);
            end
        endcase
    end

    // State, settle counter, mode and raster position registers
    always_ff @(posedge DCLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= ST_OFF;
            cnt   <= '0;
            pend  <= 2'b00;
            mode  <= 2'b00;
            h     <= '0;
            v     <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
            mode  <= mode_nxt;
            h     <= h_nxt;
            v     <= v_nxt;
        end
    end

    // Next state: disable beats everything, then a mode change restarts settling
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        mode_nxt  = mode;
        h_nxt     = h;
        v_nxt     = v;
        if (!en_s2) begin
            state_nxt = ST_OFF;
            cnt_nxt   = '0;
            h_nxt     = '0;
            v_nxt     = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = '0;
                    pend_nxt  = resol_n;
                end
                ST_SETTLE: begin
                    if (resol_n != pend) begin
                        cnt_nxt  = '0;
                        pend_nxt = resol_n;
                    end else if (cnt == SW'(SETTLE_CYC - 1)) begin
                        state_nxt = ST_RUN;
                        mode_nxt  = pend;
                        h_nxt     = '0;
                        v_nxt     = '0;
                    end else begin
                        cnt_nxt = cnt + SW'(1);
                    end
                end
                ST_RUN: begin
                    if (resol_n != mode) begin
                        state_nxt = ST_SETTLE;
                        cnt_nxt   = '0;
                        pend_nxt  = resol_n;
                    end else if (h == htot - CW'(1)) begin
                        h_nxt = '0;
                        v_nxt = (v == vtot - CW'(1)) ? '0 : v + CW'(1);
                    end else begin
                        h_nxt = h + CW'(1);
                    end
                end
                default: begin
                    state_nxt = ST_OFF;
                end
            endcase
        end
    end

    // Outputs go idle on the same edge that leaves RUN, so no partial sync leaks out
    assign run_out = (state == ST_RUN) && (state_nxt == ST_RUN);

    // Registered pixel-timing outputs, one cycle behind the internal position
    always_ff @(posedge DCLK or negedge ARESETN) begin
        if (!ARESETN) begin
            DSP_DE      <= 1'b0;
            DSP_HSYNC_X <= 1'b1;
            DSP_VSYNC_X <= 1'b1;
            HCNT        <= '0;
            VCNT        <= '0;
            FRAME_START <= 1'b0;
            READY       <= 1'b0;
        end else if (run_out) begin
            DSP_DE      <= (h < hact) && (v < vact);
            DSP_HSYNC_X <= !((h >= hs_beg) && (h < hs_end));
            DSP_VSYNC_X <= !((v >= vs_beg) && (v < vs_end));
            HCNT        <= h;
            VCNT        <= v;
            FRAME_START <= (h == '0) && (v == '0);
            READY       <= 1'b1;
        end else begin
            DSP_DE      <= 1'b0;
            DSP_HSYNC_X <= 1'b1;
            DSP_VSYNC_X <= 1'b1;
            HCNT        <= '0;
            VCNT        <= '0;
            FRAME_START <= 1'b0;
            READY       <= 1'b0;
        end
    end

`ifdef DISP_TIMING_VBLIRQ_EN
    // Vertical-blank interrupt: set at the first blank line, held until cleared
    always_ff @(posedge DCLK or negedge ARESETN) begin
        if (!ARESETN) begin
            VBL_IRQ <= 1'b0;
        end else if (!run_out) begin
            VBL_IRQ <= 1'b0;
        end else if ((h == '0) && (v == vact)) begin
            VBL_IRQ <= 1'b1;
        end else if (IRQ_CLR) begin
            VBL_IRQ <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_disp_timing_ctrl.sv
// Directed self-checking bench for disp_timing_ctrl (SETTLE_CYC = 16).
module tb_disp_timing_ctrl;

    logic        DCLK;
    logic        ARESETN;
    logic [1:0]  RESOL;
    logic        DSP_EN;
    logic        DSP_DE;
    logic        DSP_HSYNC_X;
    logic        DSP_VSYNC_X;
    logic [10:0] HCNT;
    logic [10:0] VCNT;
    logic        FRAME_START;
    logic        READY;
`ifdef DISP_TIMING_VBLIRQ_EN
    logic        IRQ_CLR;
    logic        VBL_IRQ;
`endif

    int n_vec;
    int n_err;
    int rdy_k;
    int k;

    // {HCNT, VCNT, DE, HSYNC_X, VSYNC_X, FRAME_START, READY}
    logic [26:0] obs;
    logic [26:0] e;
    localparam logic [26:0] IDLE = {22'd0, 5'b01100};

    assign obs = {HCNT, VCNT, DSP_DE, DSP_HSYNC_X, DSP_VSYNC_X, FRAME_START, READY};

    disp_timing_ctrl #(.SETTLE_CYC(16)) dut (
        .DCLK        (DCLK),
        .ARESETN     (ARESETN),
        .RESOL       (RESOL),
        .DSP_EN      (DSP_EN),
`ifdef DISP_TIMING_VBLIRQ_EN
        .IRQ_CLR     (IRQ_CLR),
        .VBL_IRQ     (VBL_IRQ),
`endif
        .DSP_DE      (DSP_DE),
        .DSP_HSYNC_X (DSP_HSYNC_X),
        .DSP_VSYNC_X (DSP_VSYNC_X),
        .HCNT        (HCNT),
        .VCNT        (VCNT),
        .FRAME_START (FRAME_START),
        .READY       (READY)
    );

    initial DCLK = 1'b0;
    always #5 DCLK = ~DCLK;

    // Expected output vector for a RUN position; window bounds hand-derived from the mode table
    function automatic logic [26:0] expv(input int m, input int h, input int v);
        int hact, hsb, hse, vact, vsb, vse;
        logic de, hs, vs, fs;
        case (m)
            1:       begin hact = 800;  hsb = 840;  hse = 968;  vact = 600;  vsb = 601;  vse = 605;  end
            2:       begin hact = 1280; hsb = 1328; hse = 1440; vact = 1024; vsb = 1025; vse = 1028; end
            default: begin hact = 640;  hsb = 656;  hse = 752;  vact = 480;  vsb = 490;  vse = 492;  end
        endcase
        de = (h < hact) && (v < vact);
        hs = !((h >= hsb) && (h < hse));
        vs = !((v >= vsb) && (v < vse));
        fs = (h == 0) && (v == 0);
        return {11'(h), 11'(v), de, hs, vs, fs, 1'b1};
    endfunction

    task automatic step();
        @(posedge DCLK);
        #1;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        DSP_EN  = 1'b1;
        RESOL   = 2'b10;
        repeat (3) step();
        n_vec++;
        if (obs !== IDLE) begin
            n_err++;
            $display("FAIL reset_idle: got %h want %h", obs, IDLE);
        end
        DSP_EN = 1'b0;
        RESOL  = 2'b00;
        step();
        ARESETN = 1'b1;
        repeat (5) step();
        n_vec++;
        if (obs !== IDLE) begin
            n_err++;
            $display("FAIL off_idle: got %h want %h", obs, IDLE);
        end
    endtask

    task automatic test_enable();
        DSP_EN = 1'b1;
        RESOL  = 2'b00;
        k = 0; rdy_k = 0;
        while (k < 60 && rdy_k == 0) begin
            step(); k++;
            if (READY === 1'b1) rdy_k = k;
        end
        n_vec++;
        if (rdy_k !== 20) begin
            n_err++;
            $display("FAIL enable_latency: got %0d want 20", rdy_k);
        end
        // two full 640x480 lines plus a few pixels
        for (int i = 0; i < 1605; i++) begin
            if (i > 0) step();
            e = expv(0, i % 800, i / 800);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL mode0_line i=%0d: got %h want %h", i, obs, e);
            end
        end
    endtask

    task automatic test_mode_change();
        // 00 -> 01 while running (position h=4, v=2)
        RESOL = 2'b01;
        step(); step();
        e = expv(0, 6, 2);
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL chg01_still_run: got %h want %h", obs, e);
        end
        step();
        n_vec++;
        if (obs !== IDLE) begin
            n_err++;
            $display("FAIL chg01_blank: got %h want %h", obs, IDLE);
        end
        k = 3; rdy_k = 0;
        while (k < 60 && rdy_k == 0) begin
            step(); k++;
            if (READY === 1'b1) rdy_k = k;
        end
        n_vec++;
        if (rdy_k !== 20) begin
            n_err++;
            $display("FAIL chg01_latency: got %0d want 20", rdy_k);
        end
        for (int i = 0; i < 1061; i++) begin
            if (i > 0) step();
            e = expv(1, i % 1056, i / 1056);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL mode1_line i=%0d: got %h want %h", i, obs, e);
            end
        end
        // 01 -> 00 mid-line at HCNT = 300
        for (int g = 0; g < 2000 && HCNT !== 11'd300; g++) step();
        RESOL = 2'b00;
        step();
        e = expv(1, 301, 1);
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL chg00_c1: got %h want %h", obs, e);
        end
        step();
        e = expv(1, 302, 1);
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL chg00_c2: got %h want %h", obs, e);
        end
        step();
        n_vec++;
        if (obs !== IDLE) begin
            n_err++;
            $display("FAIL chg00_blank: got %h want %h", obs, IDLE);
        end
        k = 3; rdy_k = 0;
        while (k < 60 && rdy_k == 0) begin
            step(); k++;
            if (READY === 1'b1) rdy_k = k;
        end
        n_vec++;
        if (rdy_k !== 20) begin
            n_err++;
            $display("FAIL chg00_latency: got %0d want 20", rdy_k);
        end
        for (int i = 0; i < 805; i++) begin
            if (i > 0) step();
            e = expv(0, i % 800, i / 800);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL mode0_after i=%0d: got %h want %h", i, obs, e);
            end
        end
    endtask

    task automatic test_resol_alias();
        // 11 is the same mode as 00: timing must continue undisturbed
        RESOL = 2'b11;
        for (int j = 1; j <= 40; j++) begin
            if (j == 31) RESOL = 2'b00;
            step();
            e = expv(0, (804 + j) % 800, (804 + j) / 800);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL alias11 j=%0d: got %h want %h", j, obs, e);
            end
        end
    endtask

    task automatic test_mode2();
        RESOL = 2'b10;
        step(); step();
        e = expv(0, 46, 1);
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL chg10_still_run: got %h want %h", obs, e);
        end
        step();
        n_vec++;
        if (obs !== IDLE) begin
            n_err++;
            $display("FAIL chg10_blank: got %h want %h", obs, IDLE);
        end
        k = 3; rdy_k = 0;
        while (k < 60 && rdy_k == 0) begin
            step(); k++;
            if (READY === 1'b1) rdy_k = k;
        end
        n_vec++;
        if (rdy_k !== 20) begin
            n_err++;
            $display("FAIL chg10_latency: got %0d want 20", rdy_k);
        end
        for (int i = 0; i < 1693; i++) begin
            if (i > 0) step();
            e = expv(2, i % 1688, i / 1688);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL mode2_line i=%0d: got %h want %h", i, obs, e);
            end
        end
    endtask

    task automatic test_disable();
        // drop enable inside HSYNC of 1280x1024
        for (int g = 0; g < 3000 && HCNT !== 11'd1330; g++) step();
        DSP_EN = 1'b0;
        step();
        e = expv(2, 1331, 1);
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL dis_c1: got %h want %h", obs, e);
        end
        step();
        e = expv(2, 1332, 1);
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL dis_c2: got %h want %h", obs, e);
        end
        for (int j = 0; j < 30; j++) begin
            step();
            n_vec++;
            if (obs !== IDLE) begin
                n_err++;
                $display("FAIL dis_idle j=%0d: got %h want %h", j, obs, IDLE);
            end
        end
        DSP_EN = 1'b1;
        k = 0; rdy_k = 0;
        while (k < 60 && rdy_k == 0) begin
            step(); k++;
            if (READY === 1'b1) rdy_k = k;
        end
        n_vec++;
        if (rdy_k !== 20) begin
            n_err++;
            $display("FAIL reen_latency: got %0d want 20", rdy_k);
        end
        for (int i = 0; i < 20; i++) begin
            if (i > 0) step();
            e = expv(2, i, 0);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL reen_run i=%0d: got %h want %h", i, obs, e);
            end
        end
    endtask

    task automatic test_off_wins();
        // enable fall together with a mode change: must go OFF and stay there
        DSP_EN = 1'b0;
        RESOL  = 2'b00;
        step(); step();
        e = expv(2, 21, 0);
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL offwin_c2: got %h want %h", obs, e);
        end
        for (int j = 0; j < 41; j++) begin
            step();
            n_vec++;
            if (obs !== IDLE) begin
                n_err++;
                $display("FAIL offwin_idle j=%0d: got %h want %h", j, obs, IDLE);
            end
        end
        DSP_EN = 1'b1;
        k = 0; rdy_k = 0;
        while (k < 60 && rdy_k == 0) begin
            step(); k++;
            if (READY === 1'b1) rdy_k = k;
        end
        n_vec++;
        if (rdy_k !== 20) begin
            n_err++;
            $display("FAIL offwin_latency: got %0d want 20", rdy_k);
        end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            e = expv(0, i, 0);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL offwin_mode0 i=%0d: got %h want %h", i, obs, e);
            end
        end
    endtask

    task automatic test_async_reset();
        // reset mid-line takes effect without waiting for a clock edge
        #2;
        ARESETN = 1'b0;
        #1;
        n_vec++;
        if (obs !== IDLE) begin
            n_err++;
            $display("FAIL async_reset: got %h want %h", obs, IDLE);
        end
        step();
        ARESETN = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        ARESETN = 1'b0;
        DSP_EN  = 1'b0;
        RESOL   = 2'b00;
`ifdef DISP_TIMING_VBLIRQ_EN
        IRQ_CLR = 1'b0;
`endif
        test_reset();
        test_enable();
        test_mode_change();
        test_resol_alias();
        test_mode2();
        test_disable();
        test_off_wins();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
